// File: rtl/dec_pkg.sv
// Shared definitions for the one-hot/thermometer decode pipe.
// Holds the mode and state encodings and a pure decode helper.
// The helper takes the vector width as an argument, so any instance width can use it.
package dec_pkg;

   localparam logic DEC_MODE_ONEHOT = 1'b0;
   localparam logic DEC_MODE_THERM  = 1'b1;

   // Occupancy of the two-entry skid buffer.
   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_BUSY  = 2'd1,
      ST_FULL  = 2'd2
   } dec_state_t;

   // Value of output bit 'pos' for a 'width'-bit decoded vector.
   // Out-of-range indices give all-zero (one-hot) or all-one (thermometer).
   function automatic logic dec_bit(input logic [31:0] idx,
                                    input logic        mode,
                                    input logic        en,
                                    input logic [31:0] width,
                                    input logic [31:0] pos);
      logic b;
      b = 1'b0;
      if (!en)
         b = 1'b0;
      else if (idx >= width)
         b = (mode == DEC_MODE_THERM);
      else if (mode == DEC_MODE_THERM)
         b = (pos <= idx);
      else
         b = (pos == idx);
      return b;
   endfunction

   // Error flag: an enabled request whose index does not fit the vector.
   function automatic logic dec_err(input logic [31:0] idx,
                                    input logic        en,
                                    input logic [31:0] width);
      return en && (idx >= width);
   endfunction

endpackage

// File: rtl/dec_onehot_pipe_if.sv
// Request/result bundle of dec_onehot_pipe.
// Request side: in_valid/in_ready/in_idx/in_mode/in_en; result side: out_valid/out_ready/out_vec/out_err.
// master = upstream+downstream user of the block, slave = the block itself.
interface dec_onehot_pipe_if #(
   parameter int IN_W  = 4,
   parameter int OUT_W = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [IN_W-1:0]  in_idx;
   logic             in_mode;
   logic             in_en;
   logic             out_valid;
   logic             out_ready;
   logic [OUT_W-1:0] out_vec;
   logic             out_err;

   modport master (
      output in_valid, in_idx, in_mode, in_en, out_ready,
      input  in_ready, out_valid, out_vec, out_err
   );

   modport slave (
      input  in_valid, in_idx, in_mode, in_en, out_ready,
      output in_ready, out_valid, out_vec, out_err
   );
endinterface

// File: rtl/skid_buf2.sv
// Generic two-entry valid/ready skid buffer (main register M feeds the output, S catches overflow).
// Latency: one cycle from input transfer to out_valid when empty; full throughput.
// Backpressure: in_ready is registered and drops only when both entries are occupied.
// Ports: clk, rst (async active-high), in_valid/in_ready/in_dat, out_valid/out_ready/out_dat.
module skid_buf2
   import dec_pkg::*;
#(
   parameter int W = 17
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_dat,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_dat
);

   dec_state_t   state_q, state_d;
   logic [W-1:0] m_q, s_q;
   logic         rdy_q;
   logic         in_xfer, out_xfer;
   logic         load_m_in, load_m_s, load_s;

   assign in_xfer  = in_valid & rdy_q;
   assign out_xfer = (state_q != ST_EMPTY) & out_ready;

   always_comb begin
      state_d   = state_q;
      load_m_in = 1'b0;
      load_m_s  = 1'b0;
      load_s    = 1'b0;
      case (state_q)
         ST_EMPTY: begin
            if (in_xfer) begin
               load_m_in = 1'b1;
               state_d   = ST_BUSY;
            end
         end
         ST_BUSY: begin
            if (in_xfer && out_xfer) begin
               load_m_in = 1'b1;
            end else if (out_xfer) begin
               state_d = ST_EMPTY;
            end else if (in_xfer) begin
               load_s  = 1'b1;
               state_d = ST_FULL;
            end
         end
         ST_FULL: begin
            // in_ready is low here, so only the output side can move.
            if (out_xfer) begin
               load_m_s = 1'b1;
               state_d  = ST_BUSY;
            end
         end
         default: state_d = ST_EMPTY;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_EMPTY;
         rdy_q   <= 1'b1;
         m_q     <= '0;
         s_q     <= '0;
      end else begin
         state_q <= state_d;
         // Registered ready: look at where we are going, never at out_ready directly.
         rdy_q   <= (state_d != ST_FULL);
         if (load_m_in)
            m_q <= in_dat;
         else if (load_m_s)
            m_q <= s_q;
         if (load_s)
            s_q <= in_dat;
      end
   end

   assign in_ready  = rdy_q;
   assign out_valid = (state_q != ST_EMPTY);
   assign out_dat   = m_q;

endmodule

// File: rtl/dec_onehot_pipe.sv
// Binary index -> one-hot or thermometer vector, registered behind a two-entry skid buffer.
// Latency: one cycle from accept to out_valid when empty; one result per cycle while out_ready = 1.
// Backpressure: registered in_ready falls only when both buffer entries hold results.
// Ports: clk, rst (async active-high), bus (slave side: in_valid/in_ready/in_idx/in_mode/in_en,
//        out_valid/out_ready/out_vec/out_err).
module dec_onehot_pipe
   import dec_pkg::*;
#(
   parameter int IN_W  = 4,
   parameter int OUT_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   dec_onehot_pipe_if.slave  bus
);

   // Reject widths the decoder cannot represent before any hardware is built.
   if (IN_W < 1 || IN_W > 31 || OUT_W < 1 || OUT_W > (1 << IN_W)) begin : g_bad_width
      $error("dec_onehot_pipe: need 1 <= OUT_W <= 2**IN_W and 1 <= IN_W <= 31");
   end

   logic [31:0]      idx_ext;
   logic [OUT_W-1:0] dec_vec;
   logic             dec_e;
   logic [OUT_W:0]   out_dat;

   assign idx_ext = 32'(bus.in_idx);

   always_comb begin
      dec_vec = '0;
      for (int i = 0; i < OUT_W; i++)
         dec_vec[i] = dec_bit(idx_ext, bus.in_mode, bus.in_en, 32'(OUT_W), 32'(i));
   end

   assign dec_e = dec_err(idx_ext, bus.in_en, 32'(OUT_W));

   // Payload packs the error flag above the vector.
   skid_buf2 #(.W(OUT_W + 1)) u_skid (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (bus.in_valid),
      .in_ready  (bus.in_ready),
      .in_dat    ({dec_e, dec_vec}),
      .out_valid (bus.out_valid),
      .out_ready (bus.out_ready),
      .out_dat   (out_dat)
   );

   assign bus.out_vec = out_dat[OUT_W-1:0];
   assign bus.out_err = out_dat[OUT_W];

endmodule
